// File: rtl/aux_input_conditioner.sv
// aux_input_conditioner: synchronises and debounces the slide switches and the
// resume push-button. Produces stable switch levels with a change strobe, plus
// clean press / auto-repeat / release pulses for the button.
module aux_input_conditioner #(
    parameter int SwtBit            = 16,
    parameter int TickCnt           = 100000,
    parameter int StableTicks       = 8,
    parameter int RepeatDelayTicks  = 500,
    parameter int RepeatPeriodTicks = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SwtBit-1:0] i_swt_raw,
    input  logic              i_btn_raw,
    output logic [SwtBit-1:0] o_swt,
    output logic              o_swt_changed,
    output logic              o_btn_level,
    output logic              o_btn_pulse,
    output logic              o_btn_release
);

    // Switches occupy the low channels; the button is the top channel.
    localparam int NumCh  = SwtBit + 1;
    localparam int BtnCh  = SwtBit;
    localparam int TickW  = $clog2(TickCnt);
    localparam int DebW   = $clog2(StableTicks + 1);
    localparam int RepMax = (RepeatDelayTicks > RepeatPeriodTicks) ? RepeatDelayTicks : RepeatPeriodTicks;
    localparam int RepW   = $clog2(RepMax + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    logic [NumCh-1:0] r_meta;
    logic [NumCh-1:0] r_sync;
    logic [TickW-1:0] r_tick_cnt;
    logic             w_tick;
    logic [NumCh-1:0] r_deb;
    logic [DebW-1:0]  r_deb_cnt [NumCh];
    logic [NumCh-1:0] w_flip;
    logic             r_swt_changed;
    logic             w_btn_rise;
    logic             w_btn_fall;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [RepW-1:0]  r_rep_cnt;
    logic [RepW-1:0]  w_rep_nxt;
    logic [RepW-1:0]  w_rep_inc;
    logic             w_pulse_nxt;
    logic             w_release_nxt;
    logic             r_btn_pulse;
    logic             r_btn_release;

    // Two-flop synchroniser for every raw pad; only the second stage is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {i_btn_raw, i_swt_raw};
            r_sync <= r_meta;
        end
    end

    // Free-running sample tick divider, wrapping at TickCnt-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TickW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TickW'(TickCnt - 1));

    // A channel flips when this tick would be the StableTicks-th disagreeing sample.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < NumCh; i++) begin
            w_flip[i] = w_tick && (r_sync[i] != r_deb[i]) &&
                        (r_deb_cnt[i] == DebW'(StableTicks - 1));
        end
    end

    // Per-channel debounce: count disagreeing ticks, clear on agreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= '0;
            for (int i = 0; i < NumCh; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < NumCh; i++) begin
                if (w_flip[i]) begin
                    r_deb[i]     <= ~r_deb[i];
                    r_deb_cnt[i] <= '0;
                end else if (r_sync[i] != r_deb[i]) begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DebW'(1);
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Change strobe registered alongside the flip so it lines up with the new o_swt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swt_changed <= 1'b0;
        end else begin
            r_swt_changed <= |w_flip[SwtBit-1:0];
        end
    end

    assign w_btn_rise = w_flip[BtnCh] && !r_deb[BtnCh];
    assign w_btn_fall = w_flip[BtnCh] &&  r_deb[BtnCh];
    assign w_rep_inc  = r_rep_cnt + RepW'(1);

    // Button FSM next-state logic; a debounced fall overrides everything else.
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_nxt     = r_rep_cnt;
        w_pulse_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_btn_fall) begin
            w_state_nxt   = IDLE;
            w_rep_nxt     = '0;
            w_release_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_btn_rise) begin
                        w_state_nxt = DELAY;
                        w_rep_nxt   = '0;
                        w_pulse_nxt = 1'b1;
                    end
                end
                DELAY: begin
                    if ((RepeatDelayTicks != 0) && w_tick) begin
                        if (w_rep_inc == RepW'(RepeatDelayTicks)) begin
                            w_state_nxt = REPEAT;
                            w_rep_nxt   = '0;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (w_tick) begin
                        if (w_rep_inc == RepW'(RepeatPeriodTicks)) begin
                            w_rep_nxt   = '0;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rep_nxt   = '0;
                end
            endcase
        end
    end

    // Button FSM state, repeat counter and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rep_cnt     <= '0;
            r_btn_pulse   <= 1'b0;
            r_btn_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rep_cnt     <= w_rep_nxt;
            r_btn_pulse   <= w_pulse_nxt;
            r_btn_release <= w_release_nxt;
        end
    end

    assign o_swt         = r_deb[SwtBit-1:0];
    assign o_btn_level   = r_deb[BtnCh];
    assign o_swt_changed = r_swt_changed;
    assign o_btn_pulse   = r_btn_pulse;
    assign o_btn_release = r_btn_release;

endmodule

// File: tb/tb_aux_input_conditioner.sv
// tb_aux_input_conditioner: directed, table-driven bench for aux_input_conditioner
// using a small tick divider and short repeat timings.
module tb_aux_input_conditioner;

    logic        clk;
    logic        rst;
    logic [15:0] swtRaw;
    logic        btnRaw;
    logic [15:0] swtOut;
    logic        swtChanged;
    logic        btnLevel;
    logic        btnPulse;
    logic        btnRelease;

    logic [15:0] swtRaw2;
    logic        btnRaw2;
    logic [15:0] swtOut2;
    logic        swtChanged2;
    logic        btnLevel2;
    logic        btnPulse2;
    logic        btnRelease2;

    int checks   = 0;
    int failures = 0;
    int ruleViolations = 0;

    int cntPulse, cntRelease, cntChanged, cntCoinc;
    int cnt2Pulse, cnt2Release;
    logic prevLevel;

    typedef struct {
        string       name;
        logic [15:0] rawVal;
        int          holdCycles;
        logic [15:0] expSwt;
        int          expChanged;
    } swtVec_t;

    swtVec_t vecs [7];

    aux_input_conditioner #(
        .SwtBit(16), .TickCnt(4), .StableTicks(3),
        .RepeatDelayTicks(5), .RepeatPeriodTicks(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_swt_raw(swtRaw), .i_btn_raw(btnRaw),
        .o_swt(swtOut), .o_swt_changed(swtChanged),
        .o_btn_level(btnLevel), .o_btn_pulse(btnPulse), .o_btn_release(btnRelease)
    );

    aux_input_conditioner #(
        .SwtBit(16), .TickCnt(4), .StableTicks(3),
        .RepeatDelayTicks(0), .RepeatPeriodTicks(2)
    ) dutNoRepeat (
        .clk(clk), .rst(rst),
        .i_swt_raw(swtRaw2), .i_btn_raw(btnRaw2),
        .o_swt(swtOut2), .o_swt_changed(swtChanged2),
        .o_btn_level(btnLevel2), .o_btn_pulse(btnPulse2), .o_btn_release(btnRelease2)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watch both instances for overlapping or back-to-back button strobes.
    logic mPrevPulse, mPrevRel, mPrevPulse2, mPrevRel2;
    always @(negedge clk) begin
        if (rst) begin
            mPrevPulse = 1'b0; mPrevRel = 1'b0; mPrevPulse2 = 1'b0; mPrevRel2 = 1'b0;
        end else begin
            if ((btnPulse && btnRelease) || (btnPulse && mPrevPulse) || (btnRelease && mPrevRel))
                ruleViolations++;
            if ((btnPulse2 && btnRelease2) || (btnPulse2 && mPrevPulse2) || (btnRelease2 && mPrevRel2))
                ruleViolations++;
            mPrevPulse = btnPulse; mPrevRel = btnRelease;
            mPrevPulse2 = btnPulse2; mPrevRel2 = btnRelease2;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearCounts();
        cntPulse = 0; cntRelease = 0; cntChanged = 0; cntCoinc = 0;
        cnt2Pulse = 0; cnt2Release = 0;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        if (btnPulse) cntPulse++;
        if (btnPulse && btnLevel && !prevLevel) cntCoinc++;
        if (btnRelease) cntRelease++;
        if (swtChanged) cntChanged++;
        if (btnPulse2) cnt2Pulse++;
        if (btnRelease2) cnt2Release++;
        prevLevel = btnLevel;
    endtask

    task automatic applyStimulus(input swtVec_t v);
        swtRaw = v.rawVal;
        clearCounts();
        repeat (v.holdCycles) stepCycle();
        checkOutput({v.name, "_swt"}, {16'h0, swtOut}, {16'h0, v.expSwt});
        checkOutput({v.name, "_changed"}, cntChanged, v.expChanged);
    endtask

    initial begin
        int bad;
        int foundAt;
        int pulseOffs [4];
        int nOffs;
        logic levelAtPulse;

        vecs[0] = '{"toZero",      16'h0000, 20, 16'h0000, 1};
        vecs[1] = '{"glitch",      16'h0001,  6, 16'h0000, 0};
        vecs[2] = '{"afterGlitch", 16'h0000, 20, 16'h0000, 0};
        vecs[3] = '{"bit0Set",     16'h0001, 20, 16'h0001, 1};
        vecs[4] = '{"allSet",      16'hFFFF, 20, 16'hFFFF, 1};
        vecs[5] = '{"mixFlip",     16'h5A5A, 20, 16'h5A5A, 1};
        vecs[6] = '{"stable",      16'h5A5A, 20, 16'h5A5A, 0};

        rst = 1'b1; swtRaw = 16'hA5A5; btnRaw = 1'b0; swtRaw2 = 16'h0; btnRaw2 = 1'b0;
        prevLevel = 1'b0;
        clearCounts();

        // Reset held with switches high: everything must stay at zero.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({swtOut, swtChanged, btnLevel, btnPulse, btnRelease} != '0) bad++;
        end
        checkOutput("resetHold", bad, 0);

        rst = 1'b0;
        clearCounts();
        foundAt = -1;
        for (int i = 1; i <= 14; i++) begin
            stepCycle();
            if (swtOut == 16'hA5A5 && foundAt < 0) foundAt = i;
        end
        checkOutput("resetSettleInTime", (foundAt >= 1 && foundAt <= 14), 1);
        repeat (10) stepCycle();
        checkOutput("resetSwt", {16'h0, swtOut}, 32'h0000A5A5);
        checkOutput("resetChangedOnce", cntChanged, 1);
        checkOutput("resetBtnQuiet", cntPulse + cntRelease, 0);

        for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

        // Bouncing button then a steady hold: one press pulse, aligned with level.
        clearCounts();
        prevLevel = btnLevel;
        for (int k = 0; k < 12; k++) begin
            btnRaw = (k % 2 == 0);
            repeat (2) stepCycle();
        end
        btnRaw = 1'b1;
        for (int i = 0; i < 20 && !btnLevel; i++) stepCycle();
        repeat (5) stepCycle();
        checkOutput("bounceLevel", btnLevel, 1);
        checkOutput("bouncePulses", cntPulse, 1);
        checkOutput("bounceCoincident", cntCoinc, 1);
        checkOutput("bounceNoRelease", cntRelease, 0);

        btnRaw = 1'b0;
        clearCounts();
        repeat (40) stepCycle();
        checkOutput("bounceReleaseOnce", cntRelease, 1);
        checkOutput("bounceReleasedLevel", btnLevel, 0);

        // Clean press and hold: pulses at 0, +20, then every 8 cycles.
        btnRaw = 1'b1;
        clearCounts();
        for (int i = 0; i < 25 && !btnLevel; i++) stepCycle();
        checkOutput("repeatPressSeen", btnLevel, 1);
        nOffs = 0;
        for (int off = 0; off <= 40; off++) begin
            if (off > 0) stepCycle();
            if (btnPulse) begin
                if (nOffs < 4) pulseOffs[nOffs] = off;
                nOffs++;
            end
        end
        checkOutput("repeatCount", nOffs, 4);
        checkOutput("repeatOff0", (nOffs > 0) ? pulseOffs[0] : -1, 0);
        checkOutput("repeatOff1", (nOffs > 1) ? pulseOffs[1] : -1, 20);
        checkOutput("repeatOff2", (nOffs > 2) ? pulseOffs[2] : -1, 28);
        checkOutput("repeatOff3", (nOffs > 3) ? pulseOffs[3] : -1, 36);

        // Asynchronous reset mid-cycle while held in REPEAT.
        checkOutput("preResetLevel", btnLevel, 1);
        #2 rst = 1'b1;
        #1 checkOutput("asyncResetOutputs", {11'h0, swtOut, swtChanged, btnLevel, btnPulse, btnRelease}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clearCounts();
        prevLevel = 1'b0;
        foundAt = -1;
        levelAtPulse = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            stepCycle();
            if (btnPulse && foundAt < 0) begin
                foundAt = i;
                levelAtPulse = btnLevel;
            end
        end
        checkOutput("reacceptLatency", (foundAt >= 9 && foundAt <= 16), 1);
        checkOutput("reacceptLevel", levelAtPulse, 1);

        btnRaw = 1'b0;
        clearCounts();
        repeat (40) stepCycle();
        checkOutput("finalRelease", cntRelease, 1);
        clearCounts();
        repeat (10) stepCycle();
        checkOutput("quietAfterRelease", cntPulse + cntRelease, 0);

        // Auto-repeat disabled instance: long hold gives one press, one release.
        btnRaw2 = 1'b1;
        clearCounts();
        repeat (200) stepCycle();
        btnRaw2 = 1'b0;
        repeat (40) stepCycle();
        checkOutput("noRepeatPulses", cnt2Pulse, 1);
        checkOutput("noRepeatReleases", cnt2Release, 1);
        checkOutput("noRepeatSwt", {16'h0, swtOut2}, 0);

        checkOutput("pulseRules", ruleViolations, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aux_input_conditioner.md
Name: aux_input_conditioner

Overview:
Front-end conditioner for the board's user inputs: slide switches and the resume push-button. Raw pad inputs are synchronised and debounced. The block outputs stable switch values, a change strobe, and clean single-cycle button press, auto-repeat and release pulses. It sits between the board pins and the switch-decode and halt/resume logic in the top level. It is the input-side counterpart of the display scan path.

Parameters:
SwtBit, 16, number of switch channels.
TickCnt, 100000, clk cycles per debounce sample tick (1 kHz at 100 MHz); must be >= 2.
StableTicks, 8, consecutive disagreeing ticks required to accept a new level; must be >= 1.
RepeatDelayTicks, 500, ticks of continuous hold before the first auto-repeat; 0 disables auto-repeat.
RepeatPeriodTicks, 100, ticks between auto-repeat pulses; must be >= 1.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
swt_raw  in  SwtBit  raw switch pins, asynchronous to clk.
btn_raw  in  1  raw push-button pin, asynchronous, active-high.
swt  out  SwtBit  debounced switch levels.
swt_changed  out  1  one-cycle strobe: some bit of swt changed this cycle.
btn_level  out  1  debounced button level.
btn_pulse  out  1  one-cycle strobe on press and on each auto-repeat.
btn_release  out  1  one-cycle strobe on debounced release.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. While rst is high, all flops clear immediately, independent of clk. All outputs are 0 in reset and stay 0 until a debounced change occurs.
- Synchroniser: two flops per raw input, reset value 0. Only the second-stage value feeds the logic.
- Tick generator: counter runs 0..TickCnt-1 and wraps to 0. tick is high for exactly one cycle when the counter equals TickCnt-1. Reset sets the counter to 0.
- Debounce, per channel (SwtBit switches plus button, identical logic):
  - Each channel has a counter of width clog2(StableTicks+1).
  - On a tick, if the synced value differs from the debounced value, the counter increments. If the values are equal, the counter clears to 0.
  - When an increment would reach StableTicks, the debounced value flips in the next cycle and the counter clears.
  - Non-tick cycles hold all counters.
  - Any glitch shorter than StableTicks ticks is rejected.
  - Acceptance latency after the raw input settles: 2 sync cycles plus between (StableTicks-1)*TickCnt+1 and StableTicks*TickCnt cycles.
- swt_changed is high exactly in the first cycle that the new swt value is visible. If several bits flip in the same cycle, it produces one pulse.
- Button FSM has states IDLE, DELAY and REPEAT, plus a tick counter of width clog2(max(RepeatDelayTicks,RepeatPeriodTicks)+1).
  - IDLE: on a debounced rise, go to DELAY, clear the counter, and assert btn_pulse in the same cycle btn_level first reads 1.
  - DELAY: increment the counter on each tick. When the count reaches RepeatDelayTicks, assert btn_pulse for one cycle, clear the counter and go to REPEAT. If RepeatDelayTicks=0, the block stays in DELAY with no repeats.
  - REPEAT: increment the counter on each tick. On reaching RepeatPeriodTicks, assert btn_pulse and clear the counter.
  - Any state with a debounced fall: go to IDLE, assert btn_release in the first cycle btn_level reads 0, and suppress any btn_pulse that would occur in that cycle.
  - A repeat expiry and a debounced fall on the same cycle resolve as release only.
- btn_pulse and btn_release are never high together and are never high for two consecutive cycles.
- Reset mid-operation: the FSM returns to IDLE and all pulses are dropped. If the button is still held after reset, it is re-accepted as a fresh press only after full debounce.
- Inputs that are high at reset release debounce normally. This yields one swt_changed pulse and/or one btn_pulse afterwards. This behaviour is intended.

Test Plan:
(All scenarios use TickCnt=4, StableTicks=3, RepeatDelayTicks=5, RepeatPeriodTicks=2.)
- Reset scenario: hold rst for 10 cycles with swt_raw=16'hA5A5 and btn_raw=0 -> all outputs 0 during reset. After release, swt=16'hA5A5 within 14 cycles, with exactly one swt_changed pulse and no further pulses.
- Glitch rejection: with swt=0, pulse swt_raw[0]=1 for 6 cycles, then return to 0 -> swt stays 16'h0000 and swt_changed never asserts. Then hold swt_raw[0]=1 for 20 cycles -> swt=16'h0001 with one swt_changed pulse.
- Bounce: toggle btn_raw every 2 cycles for 24 cycles, then hold it at 1 -> exactly one btn_pulse, coincident with btn_level rising to 1, and no btn_release.
- Auto-repeat: hold btn_raw=1 after acceptance -> btn_pulse at press, again 20 cycles later (5 ticks), then every 8 cycles. Release -> btn_release is a single pulse and btn_pulse stops.
- Async reset in REPEAT: assert rst mid-cycle while the button is held -> outputs drop to 0 before the next clk edge. After deassert with the button still held, the next btn_pulse appears only after full debounce (at least 9 cycles).
- Repeat disabled: RepeatDelayTicks=0 with a 200-cycle hold -> exactly one btn_pulse and one btn_release.
